// File: rtl/shift_reg_with_valid_pkg.sv
// rtl/shift_reg_with_valid_pkg.sv - default geometry shared by the delay-line top and its bench
package shift_reg_with_valid_pkg;

    // Default word width and latency (stages) of the delay line
    localparam int SRV_DEFAULT_WIDTH = 8;
    localparam int SRV_DEFAULT_DEPTH = 8;

endpackage

// File: rtl/vld_shift_chain.sv
// rtl/vld_shift_chain.sv - 1-bit valid delay chain with synchronous active-high clear
module vld_shift_chain #(
    parameter int depth = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    output logic [depth-1:0] vld_stages
);

    logic [depth-1:0] vld_d;
    logic [depth-1:0] vld_q;

    // Next value of each stage is the stage before it; stage 0 takes the input flag
    always_comb begin
        vld_d    = '0;
        vld_d[0] = in_vld;
        for (int i = 1; i < depth; i++) begin
            vld_d[i] = vld_q[i-1];
        end
    end

    // Reset drops every in-flight valid at once and ignores in_vld on that edge
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    assign vld_stages = vld_q;

endmodule

// File: rtl/shift_reg_with_valid.sv
// rtl/shift_reg_with_valid.sv - fixed-latency data+valid delay line; SHIFT_REG_DATA_GATE_EN gates data-stage loads on valid
module shift_reg_with_valid
    import shift_reg_with_valid_pkg::*;
#(
    parameter int width = SRV_DEFAULT_WIDTH,
    parameter int depth = SRV_DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic [width-1:0] in_data,
    output logic             out_vld,
    output logic [width-1:0] out_data
);

    logic [depth-1:0] vld_stages;
    logic [depth-1:0] data_ld;
    logic [width-1:0] data_d [depth];
    logic [width-1:0] data_q [depth];

    vld_shift_chain #(
        .depth (depth)
    ) u_vld_chain (
        .clk        (clk),
        .rst        (rst),
        .in_vld     (in_vld),
        .vld_stages (vld_stages)
    );

`ifdef SHIFT_REG_DATA_GATE_EN
    // A data stage only toggles when the valid entering it is set
    always_comb begin
        data_ld    = '0;
        data_ld[0] = in_vld;
        for (int i = 1; i < depth; i++) begin
            data_ld[i] = vld_stages[i-1];
        end
    end
`else
    // Only the last valid stage is observed when data shifts freely
    logic unused_vld_stages;
    assign unused_vld_stages = ^vld_stages;

    // Data stages shift every cycle
    always_comb begin
        data_ld = '1;
    end
`endif

    // Each data stage either takes its predecessor or holds
    always_comb begin
        data_d[0] = data_ld[0] ? in_data : data_q[0];
        for (int i = 1; i < depth; i++) begin
            data_d[i] = data_ld[i] ? data_q[i-1] : data_q[i];
        end
    end

    // Data chain carries no reset; its content is meaningful only beside a set valid
    always_ff @(posedge clk) begin
        for (int i = 0; i < depth; i++) begin
            data_q[i] <= data_d[i];
        end
    end

    assign out_vld  = vld_stages[depth-1];
    assign out_data = data_q[depth-1];

endmodule

// File: tb/tb_shift_reg_with_valid.sv
// tb/tb_shift_reg_with_valid.sv - scoreboard bench for depth-8 and depth-1 delay lines
module tb_shift_reg_with_valid;

    logic       clk;
    logic       rst;
    logic       in_vld;
    logic [7:0] in_data;
    logic       out_vld8;
    logic [7:0] out_data8;
    logic       out_vld1;
    logic [7:0] out_data1;

    typedef struct packed {
        logic       vld;
        logic [7:0] data;
    } ent_t;

    ent_t q8[$];
    ent_t q1[$];
    int   total;
    int   bad;

    shift_reg_with_valid #(.width(8), .depth(8)) dut8 (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (in_vld),
        .in_data  (in_data),
        .out_vld  (out_vld8),
        .out_data (out_data8)
    );

    shift_reg_with_valid #(.width(8), .depth(1)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (in_vld),
        .in_data  (in_data),
        .out_vld  (out_vld1),
        .out_data (out_data1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one cycle, update the models, then compare whatever has emerged
    task automatic step(input logic r, input logic v, input logic [7:0] d);
        ent_t e;
        rst     = r;
        in_vld  = v;
        in_data = d;
        if (r) begin
            for (int i = 0; i < q8.size(); i++) begin
                e = q8[i]; e.vld = 1'b0; q8[i] = e;
            end
            for (int i = 0; i < q1.size(); i++) begin
                e = q1[i]; e.vld = 1'b0; q1[i] = e;
            end
        end
        e.vld  = r ? 1'b0 : v;
        e.data = d;
        q8.push_back(e);
        q1.push_back(e);
        @(posedge clk);
        #1;
        if (q8.size() >= 8) begin
            e = q8.pop_front();
            check("vld_d8", {31'd0, out_vld8}, {31'd0, e.vld});
            if (e.vld === 1'b1) check("data_d8", {24'd0, out_data8}, {24'd0, e.data});
        end
        if (q1.size() >= 1) begin
            e = q1.pop_front();
            check("vld_d1", {31'd0, out_vld1}, {31'd0, e.vld});
            if (e.vld === 1'b1) check("data_d1", {24'd0, out_data1}, {24'd0, e.data});
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        in_vld  = 1'b0;
        in_data = 8'h00;
        #1;

        // reset, then a single A5 pulse
        repeat (3) step(1'b1, 1'b0, 8'h00);
        check("rst_vld_d8", {31'd0, out_vld8}, 32'd0);
        check("rst_vld_d1", {31'd0, out_vld1}, 32'd0);
        step(1'b0, 1'b1, 8'hA5);
        repeat (12) step(1'b0, 1'b0, 8'h00);

        // back-to-back stream 00..0F
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, i[7:0]);
        repeat (10) step(1'b0, 1'b0, 8'h00);

        // unknown valid ahead of reset must not survive it
        step(1'b0, 1'bx, 8'hxx);
        step(1'b0, 1'bx, 8'hxx);
        repeat (3) step(1'b1, 1'bx, 8'hxx);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 8'h00);
            check("xsafe_vld_d8", {31'd0, out_vld8}, 32'd0);
        end

        // mid-stream reset drops 11..15
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h11 + i[7:0]);
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 8'h00);
            check("midrst_vld_d8", {31'd0, out_vld8}, 32'd0);
        end

        // valid accepted on the first cycle after reset falls
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h3C);
        repeat (9) step(1'b0, 1'b0, 8'h00);

        // random reset/run iterations
        for (int it = 0; it < 24; it++) begin
            repeat ($urandom_range(3, 1)) step(1'b1, 1'($urandom), 8'($urandom));
            for (int c = 0; c < 24; c++) step(1'b0, 1'($urandom), 8'($urandom));
        end
        repeat (10) step(1'b0, 1'b0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
